multibuffer_pack_queue: RTL
===========================

# multibuffer_pack_queue

Upsizing counterpart of the multibuffer queue: accepts narrow words on the write side, packs them into wide lines, and stores whole lines in a banked RAM. The read side returns one wide line per accepted read after a fixed two-cycle latency. The block sits where a narrow producer (for example, 64-bit stream logic) feeds a wide consumer (for example, a 128-bit memory or DMA port).

## Interface
Parameters:
- DATA_IN_WIDTH, 64, narrow write word width.
- Q_DATA_WIDTH, 128, wide line width. R = Q_DATA_WIDTH/DATA_IN_WIDTH must be a power of two and at least 2.
- M_BUFF_NUM, 4, number of RAM banks. Must be a power of two.
- M_BUFF_ADDR_WIDTH, 10, address width per bank. DEPTH = M_BUFF_NUM * 2^M_BUFF_ADDR_WIDTH lines.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- write_en  in  1  offer data_in this cycle.
- data_in  in  DATA_IN_WIDTH  narrow write word.
- waitrequest  out  1  when high, the offered word is not accepted. Equals full.
- read_en  in  1  request one line.
- data_out  out  Q_DATA_WIDTH  registered wide line.
- data_valid  out  1  data_out is valid this cycle.
- full  out  1  stored lines == DEPTH.
- empty  out  1  stored lines == 0. A partially packed line does not count.
- almost_full  out  1  stored lines >= DEPTH - 2^M_BUFF_ADDR_WIDTH (one bank from full).
- flush  in  1  present only with PACK_FLUSH_EN.

## Operation
- **Write accept:** a word is accepted when write_en && !waitrequest. A rejected word leaves all state unchanged.
- **Lane placement:** the k-th accepted word of a line (k = 0..R-1) occupies bits [(k+1)*DATA_IN_WIDTH-1 : k*DATA_IN_WIDTH]. Lane 0 is the LSB.
- **Pack state:** a pack register holds lanes 0..R-2. A lane counter (log2(R) bits) counts words accepted into the current line.
- **Commit:** on acceptance with lane counter == R-1, the line {data_in, pack register} is written to RAM at write_addr. write_addr increments, and the lane counter wraps to 0.
- **Pointers:** write_addr and read_addr each have log2(DEPTH)+1 bits; the extra MSB is a wrap bit. The upper log2(M_BUFF_NUM) bits of the address select the bank.
  - Stored lines = write_addr - read_addr (modulo 2^(log2(DEPTH)+1)).
  - Wrap-around is natural pointer overflow.
- **Read issue:** a read is issued when read_en && !empty. Issue reads RAM at read_addr and increments read_addr. read_en while empty is ignored, with no error.
- **Status flags:** full, empty and almost_full are registers loaded from next-state pointer values, so they are exact in the cycle after the pointer change.
- **Simultaneous commit and read:** stored lines are unchanged. Both pointers advance.
- **Full boundary:** waitrequest stays high for every lane, including non-final lanes. The pack register and lane counter hold.
- **Empty boundary with commit:** a commit into an empty queue deasserts empty on the next edge. A read may be issued in that cycle.
- **Reset, including mid-operation:**
  - Pointers, lane counter and the read pipeline are cleared.
  - Outputs: data_out=0, data_valid=0, empty=1, full=0, almost_full=0, waitrequest=0.
  - Reads in flight are discarded.
  - A partial pack is lost.
  - RAM contents are not cleared.

## Timing
- **Read latency:** a read issued at edge N gives data_out/data_valid at edge N+2. Stage 1 is the registered RAM read; stage 2 is the output register.
- **data_valid:** high for exactly one cycle per issued read. Back-to-back issues give back-to-back valid cycles, for a sustained rate of one line per clock.
- **data_out hold:** data_out holds its last value while data_valid is low.
- **Write throughput:** one word per clock, which is one line per R clocks.
- **Read-after-commit:** the earliest read of a line committed at edge N is issued at edge N+1. Data appears at N+3.

## Configuration
- **Macro:** PACK_FLUSH_EN.
- **Defined:** the flush input exists.
  - flush high, !full and (lane counter > 0 or an accepted write this cycle): the current line is committed with the accepted word (if any) placed in its lane. Unfilled lanes are zero. The lane counter goes to 0.
  - flush while full: the flush is ignored.
  - flush with lane counter 0 and no write: no-op.
- **Undefined:** there is no flush port. A partial line stays invisible to the read side until R words complete it.

## Test plan
- **Pack and readback:** after reset, write 0x11, 0x22 (R=2), then read_en one cycle -> exactly one data_valid pulse at +2 cycles with data_out=0x0000000000000022_0000000000000011.
- **Fill and wrap:** fill to DEPTH lines -> full=waitrequest=1, and a further write is rejected with lane counter unchanged. Read one line -> full=0. Then write/read 3*DEPTH lines -> data order intact across pointer wrap.
- **Empty read:** read_en held on an empty queue -> no data_valid and no pointer change. Commit a line while read_en is held -> exactly one valid at the expected cycle.
- **Concurrent traffic:** simultaneous commit and read at DEPTH-1 lines -> full stays 0 and the count stays DEPTH-1. Crossing DEPTH - 2^M_BUFF_ADDR_WIDTH toggles almost_full exactly on the threshold.
- **Reset mid-read:** rst asserted one cycle after a read is issued -> data_valid stays 0, and empty=1 next cycle.
- **Flush (PACK_FLUSH_EN):** write 0xAA, then pulse flush -> the read returns 0x0000000000000000_00000000000000AA. Flush with lane 0 and no write -> the stored count is unchanged.

Source files
------------

// File: rtl/multibuffer_pack_queue.sv
// Narrow-to-wide packing queue: words are packed into lines and stored in banked RAM.
// Optional PACK_FLUSH_EN adds a flush input that commits a partial line with zero-filled lanes.
module multibuffer_pack_queue #(
    parameter int DATA_IN_WIDTH     = 64,
    parameter int Q_DATA_WIDTH      = 128,
    parameter int M_BUFF_NUM        = 4,
    parameter int M_BUFF_ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write_en,
    input  logic [DATA_IN_WIDTH-1:0] data_in,
    output logic                     waitrequest,
    input  logic                     read_en,
    output logic [Q_DATA_WIDTH-1:0]  data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full
`ifdef PACK_FLUSH_EN
    ,
    input  logic                     flush
`endif
);
    localparam int R          = Q_DATA_WIDTH / DATA_IN_WIDTH;
    localparam int LANE_W     = $clog2(R);
    localparam int BANK_DEPTH = 2 ** M_BUFF_ADDR_WIDTH;
    localparam int DEPTH      = M_BUFF_NUM * BANK_DEPTH;
    localparam int LW         = $clog2(DEPTH);
    localparam int PW         = LW + 1;
    localparam int PACK_W     = (R - 1) * DATA_IN_WIDTH;
    localparam int BSEL_W     = (M_BUFF_NUM > 1) ? $clog2(M_BUFF_NUM) : 1;

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           count_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [PACK_W-1:0]       pack_q, pack_d;
    logic                    full_q, empty_q, almost_full_q;
    logic                    accept, commit, issue, flush_req;
    logic [Q_DATA_WIDTH-1:0] line_w;

    logic                    iss_q;
    logic [LW-1:0]           raddr_q;
    logic                    v1_q;
    logic [BSEL_W-1:0]       rd_bank_q;
    logic                    data_valid_q;
    logic [Q_DATA_WIDTH-1:0] data_out_q;
    logic [Q_DATA_WIDTH-1:0] bank_rd [M_BUFF_NUM];
    logic [LW-1:0]           wr_line;

    assign wr_line = wr_ptr_q[LW-1:0];

    always_comb begin
        accept = write_en && !full_q;
        issue  = read_en && !empty_q;
`ifdef PACK_FLUSH_EN
        flush_req = flush && !full_q && ((lane_q != '0) || accept);
`else
        flush_req = 1'b0;
`endif
        commit = (accept && (lane_q == LANE_W'(R - 1))) || flush_req;

        // Unfilled lanes of the pack register are kept zero, so a flushed line is zero-filled.
        line_w = {{DATA_IN_WIDTH{1'b0}}, pack_q};
        if (accept) begin
            line_w[int'(lane_q) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_in;
        end

        pack_d = pack_q;
        lane_d = lane_q;
        if (commit) begin
            pack_d = '0;
            lane_d = '0;
        end else if (accept) begin
            pack_d[int'(lane_q) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_in;
            lane_d = lane_q + LANE_W'(1);
        end

        wr_ptr_d = commit ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = issue  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            lane_q        <= '0;
            pack_q        <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            almost_full_q <= 1'b0;
            iss_q         <= 1'b0;
            raddr_q       <= '0;
            v1_q          <= 1'b0;
            rd_bank_q     <= '0;
            data_valid_q  <= 1'b0;
            data_out_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            lane_q        <= lane_d;
            pack_q        <= pack_d;
            full_q        <= (count_d == PW'(DEPTH));
            empty_q       <= (count_d == '0);
            almost_full_q <= (count_d >= PW'(DEPTH - BANK_DEPTH));
            // Read pipeline: latch address, registered RAM read, output register.
            iss_q         <= issue;
            if (issue) begin
                raddr_q <= rd_ptr_q[LW-1:0];
            end
            v1_q          <= iss_q;
            if (iss_q) begin
                rd_bank_q <= BSEL_W'(raddr_q >> M_BUFF_ADDR_WIDTH);
            end
            data_valid_q  <= v1_q;
            if (v1_q) begin
                data_out_q <= bank_rd[rd_bank_q];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < M_BUFF_NUM; gi++) begin : g_bank
            logic [Q_DATA_WIDTH-1:0] mem [BANK_DEPTH];
            logic [Q_DATA_WIDTH-1:0] rd_q;

            always_ff @(posedge clk) begin
                if (commit && ((wr_line >> M_BUFF_ADDR_WIDTH) == LW'(gi))) begin
                    mem[wr_line[M_BUFF_ADDR_WIDTH-1:0]] <= line_w;
                end
                if (iss_q && ((raddr_q >> M_BUFF_ADDR_WIDTH) == LW'(gi))) begin
                    rd_q <= mem[raddr_q[M_BUFF_ADDR_WIDTH-1:0]];
                end
            end

            assign bank_rd[gi] = rd_q;
        end
    endgenerate

    assign waitrequest = full_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign almost_full = almost_full_q;
    assign data_valid  = data_valid_q;
    assign data_out    = data_out_q;
endmodule
